// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, in-order icache requests,
// and a small PC/instruction queue feeding decode, with redirect flush and response discard.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h1C000000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h03400000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_req_valid_o,
    input  logic        icache_req_ready_i,
    output logic [31:0] icache_req_addr_o,
    input  logic        icache_rsp_valid_i,
    input  logic [31:0] icache_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_o,
    output logic        inst_adef_o
);

    localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]    state_q;
    logic [31:0]   fetch_pc_q;
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] pend_q;
    logic [CW-1:0] drop_q;

    logic          alloc_q  [DEPTH];
    logic          filled_q [DEPTH];
    logic          adef_q   [DEPTH];
    logic [31:0]   pc_q     [DEPTH];
    logic [31:0]   inst_q   [DEPTH];

    logic [CW:0]   occupancy;
    logic          accept;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          head_valid;
    logic [AW-1:0] fill_idx;

    assign occupancy = {1'b0, count_q} + {1'b0, drop_q};

    assign icache_req_valid_o = rst && (state_q == ST_RUN) && !redirect_i
                                && (occupancy < {1'b0, DEPTH_C});
    assign icache_req_addr_o  = fetch_pc_q;

    assign accept     = icache_req_valid_o && icache_req_ready_i;
    assign head_valid = alloc_q[head_q] && filled_q[head_q];
    assign pop        = head_valid && id_ready_i;
    assign rsp_drop   = icache_rsp_valid_i && (drop_q != '0);
    assign rsp_fill   = icache_rsp_valid_i && (drop_q == '0) && (pend_q != '0);

    // Unfilled entries are always the youngest pend_q allocations, so the oldest sits pend_q behind tail.
    assign fill_idx = tail_q - pend_q[AW-1:0];

    assign inst_valid_o = head_valid;
    assign inst_pc_o    = head_valid ? pc_q[head_q]   : '0;
    assign inst_o       = head_valid ? inst_q[head_q] : '0;
    assign inst_adef_o  = head_valid && adef_q[head_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            alloc_q    <= '{default: 1'b0};
            filled_q   <= '{default: 1'b0};
            adef_q     <= '{default: 1'b0};
            pc_q       <= '{default: '0};
            inst_q     <= '{default: '0};
        end else if (redirect_i) begin
            fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            drop_q     <= drop_q + pend_q - CW'(icache_rsp_valid_i);
            head_q     <= '0;
            pend_q     <= '0;
            alloc_q    <= '{default: 1'b0};
            filled_q   <= '{default: 1'b0};
            adef_q     <= '{default: 1'b0};
            if (redirect_pc_i[1:0] == 2'b00) begin
                state_q <= ST_RUN;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                state_q     <= ST_HALT;
                alloc_q[0]  <= 1'b1;
                filled_q[0] <= 1'b1;
                adef_q[0]   <= 1'b1;
                pc_q[0]     <= redirect_pc_i;
                inst_q[0]   <= NOP_INST;
                tail_q      <= AW'(1);
                count_q     <= CW'(1);
            end
        end else begin
            if (pop) begin
                alloc_q[head_q]  <= 1'b0;
                filled_q[head_q] <= 1'b0;
                adef_q[head_q]   <= 1'b0;
                head_q           <= head_q + 1'b1;
            end
            if (rsp_fill) begin
                filled_q[fill_idx] <= 1'b1;
                inst_q[fill_idx]   <= icache_rsp_data_i;
            end
            if (accept) begin
                alloc_q[tail_q]  <= 1'b1;
                filled_q[tail_q] <= 1'b0;
                adef_q[tail_q]   <= 1'b0;
                pc_q[tail_q]     <= fetch_pc_q;
                tail_q           <= tail_q + 1'b1;
                fetch_pc_q       <= fetch_pc_q + 32'd4;
            end
            count_q <= count_q + CW'(accept) - CW'(pop);
            pend_q  <= pend_q + CW'(accept) - CW'(rsp_fill);
            if (rsp_drop) begin
                drop_q <= drop_q - 1'b1;
            end
        end
    end

    a_rsp_has_slot: assert property (@(posedge clk) disable iff (!rst)
        icache_rsp_valid_i |-> ((drop_q != '0) || (pend_q != '0)));

    // The fault entry can push occupancy one past DEPTH while halted; no request can issue there.
    a_occupancy: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ST_HALT) || (occupancy <= {1'b0, DEPTH_C}));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: icache model with random ready/latency, expected decode stream
// generated per redirect target, compared by an independent monitor.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h1C000000;
    localparam logic [31:0] NOP_INST = 32'h03400000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_req_valid_o;
    logic        icache_req_ready_i;
    logic [31:0] icache_req_addr_o;
    logic        icache_rsp_valid_i;
    logic [31:0] icache_rsp_data_i;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_ready_i    = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_o;
    logic        inst_adef_o;

    if_fetch_queue #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_req_valid_o(icache_req_valid_o),
        .icache_req_ready_i(icache_req_ready_i),
        .icache_req_addr_o (icache_req_addr_o),
        .icache_rsp_valid_i(icache_rsp_valid_i),
        .icache_rsp_data_i (icache_rsp_data_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .id_ready_i        (id_ready_i),
        .inst_valid_o      (inst_valid_o),
        .inst_pc_o         (inst_pc_o),
        .inst_o            (inst_o),
        .inst_adef_o       (inst_adef_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct packed {
        logic [31:0] addr;
        int          cyc;
    } acc_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    exp_t        exp_q[$];
    logic [31:0] gen_pc   = RESET_PC;
    bit          gen_halt = 1'b0;
    pend_t       ic_q[$];
    acc_t        acc_log[$];
    int          last_due  = 0;
    int          lat_min   = 2;
    int          lat_max   = 2;
    int          ready_pct = 100;
    int          xfer_cnt  = 0;
    logic [31:0] last_pc   = '0;
    int          first_valid_cyc = -1;
    logic [31:0] first_valid_pc  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        if (!gen_halt) begin
            while (exp_q.size() < 16) begin
                exp_q.push_back('{pc: gen_pc, inst: mem_word(gen_pc), adef: 1'b0});
                gen_pc += 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        exp_q.delete();
        if (target[1:0] == 2'b00) begin
            gen_pc   = target;
            gen_halt = 1'b0;
        end else begin
            exp_q.push_back('{pc: target, inst: NOP_INST, adef: 1'b1});
            gen_halt = 1'b1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b0;
        redirect_i = 1'b0;
        exp_q.delete();
        gen_pc   = RESET_PC;
        gen_halt = 1'b0;
        first_valid_cyc = -1;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_req_valid", {31'b0, icache_req_valid_o}, 32'h0);
            check("rst_req_addr", icache_req_addr_o, RESET_PC);
            check("rst_inst_valid", {31'b0, inst_valid_o}, 32'h0);
            check("rst_inst_pc", inst_pc_o, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        acc_log.delete();
        topup();
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        int          r;
        r = $urandom_range(99);
        t = $urandom;
        if (r < 10) t = 32'hFFFF_FFF0;
        else if (r < 25) t[1:0] = 2'($urandom_range(3, 1));
        else t[1:0] = 2'b00;
        return t;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // icache model: random ready, in-order responses at least one cycle after acceptance
    initial begin : icache
        pend_t p;
        icache_req_ready_i = 1'b0;
        icache_rsp_valid_i = 1'b0;
        icache_rsp_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                ic_q.delete();
                last_due = 0;
                icache_req_ready_i = 1'b0;
                icache_rsp_valid_i = 1'b0;
            end else begin
                icache_req_ready_i = ($urandom_range(99) < ready_pct);
                if (ic_q.size() > 0 && ic_q[0].due <= cyc) begin
                    p = ic_q.pop_front();
                    icache_rsp_valid_i = 1'b1;
                    icache_rsp_data_i  = mem_word(p.addr);
                end else begin
                    icache_rsp_valid_i = 1'b0;
                    icache_rsp_data_i  = $urandom;
                end
            end
        end
    end

    always @(negedge clk) begin
        int due;
        if (rst && icache_req_valid_o && icache_req_ready_i) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ic_q.push_back('{addr: icache_req_addr_o, due: due});
            acc_log.push_back('{addr: icache_req_addr_o, cyc: cyc});
        end
    end

    // Monitor: every decode handshake must match the head of the expected stream
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (inst_valid_o && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_valid_pc  = inst_pc_o;
            end
            if (inst_valid_o && id_ready_i && !redirect_i) begin
                xfer_cnt++;
                last_pc = inst_pc_o;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got pc %h, want no output (t=%0t)", inst_pc_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc", inst_pc_o, e.pc);
                    check("xfer_inst", inst_o, e.inst);
                    check("xfer_adef", {31'b0, inst_adef_o}, {31'b0, e.adef});
                end
            end
            if (!inst_valid_o)
                check("idle_payload", inst_pc_o | inst_o | {31'b0, inst_adef_o}, 32'h0);
            if (gen_halt && !redirect_i)
                check("halt_no_req", {31'b0, icache_req_valid_o}, 32'h0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int x0;

        // Startup stream and first-output latency
        id_ready_i = 1'b1;
        do_reset(3);
        for (int k = 0; k < 20 && acc_log.size() < 3; k++) tick();
        check("A_accepts", acc_log.size(), 3);
        if (acc_log.size() >= 3) begin
            check("A_addr0", acc_log[0].addr, 32'h1C000000);
            check("A_addr1", acc_log[1].addr, 32'h1C000004);
            check("A_addr2", acc_log[2].addr, 32'h1C000008);
            check("A_back_to_back", acc_log[2].cyc - acc_log[0].cyc, 2);
        end
        for (int k = 0; k < 20 && first_valid_cyc < 0; k++) tick();
        check("A_first_valid_lat", first_valid_cyc - acc_log[0].cyc, 3);
        check("A_first_valid_pc", first_valid_pc, RESET_PC);
        repeat (10) tick();

        // Back-pressure: queue fills to DEPTH, one pop lets exactly one request through
        id_ready_i = 1'b0;
        do_reset(2);
        repeat (12) tick();
        check("B_accepts", acc_log.size(), DEPTH);
        @(negedge clk);
        check("B_req_stalled", {31'b0, icache_req_valid_o}, 32'h0);
        check("B_head_valid", {31'b0, inst_valid_o}, 32'h1);
        tick();
        id_ready_i = 1'b1;
        @(negedge clk);
        check("B_pop_pc", inst_pc_o, 32'h1C000000);
        tick();
        id_ready_i = 1'b0;
        repeat (10) tick();
        check("B_accepts_after_pop", acc_log.size(), DEPTH + 1);
        if (acc_log.size() >= 5) check("B_new_addr", acc_log[4].addr, 32'h1C000010);

        // Redirect with two unfilled requests and a same-cycle response
        id_ready_i = 1'b1;
        do_reset(2);
        repeat (8) tick();
        x0 = xfer_cnt;
        acc_log.delete();
        do_redirect(32'h1C000100);
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 20 && xfer_cnt == x0; k++) tick();
        check("C_first_pc", last_pc, 32'h1C000100);
        check("C_first_req", acc_log[0].addr, 32'h1C000100);

        // Misaligned redirect: one fault output, no requests, then resume
        repeat (6) tick();
        x0 = xfer_cnt;
        acc_log.delete();
        do_redirect(32'h1C000102);
        tick();
        redirect_i = 1'b0;
        repeat (10) tick();
        check("D_no_req", acc_log.size(), 0);
        check("D_one_out", xfer_cnt - x0, 1);
        check("D_fault_pc", last_pc, 32'h1C000102);
        x0 = xfer_cnt;
        do_redirect(32'h1C000200);
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 20 && xfer_cnt == x0; k++) tick();
        check("D_resume_req", acc_log.size() > 0 ? acc_log[0].addr : 32'h0, 32'h1C000200);
        check("D_resume_pc", last_pc, 32'h1C000200);

        // Pop colliding with redirect is ignored
        repeat (8) tick();
        do_redirect(32'h1C000300);
        @(negedge clk);
        check("E_valid_at_redirect", {31'b0, inst_valid_o}, 32'h1);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("E_valid_after", {31'b0, inst_valid_o}, 32'h0);

        // Random ready, latency, stalls and redirects
        lat_min   = 1;
        lat_max   = 5;
        ready_pct = 70;
        x0 = xfer_cnt;
        for (int k = 0; k < 3000; k++) begin
            tick();
            id_ready_i = ($urandom_range(99) < 75);
            redirect_i = 1'b0;
            if ($urandom_range(99) < 3) do_redirect(rand_target());
        end
        tick();
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        repeat (30) tick();
        check("F_progress", {31'b0, (xfer_cnt - x0) > 300}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
